// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of one single-port, fixed-latency memory.
// Round-robin on ties, one transaction in flight, registered read data and one-cycle acks.
module mem_port_arbiter #(
   parameter int MEM_LAT = 1,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ack,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic          busy,
   output logic          grant
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [3:0] LAT_LD = 4'(MEM_LAT);

   state_t        r_state;
   logic          r_grant;
   logic          r_we;
   logic [3:0]    r_cnt;
   logic          r_m_en;
   logic          r_m_we;
   logic [AW-1:0] r_m_addr;
   logic [DW-1:0] r_m_wdata;
   logic          r_i_ack;
   logic          r_d_ack;
   logic [DW-1:0] r_i_rdata;
   logic [DW-1:0] r_d_rdata;
   logic          r_busy;

   state_t        w_state_nxt;
   logic          w_grant_nxt;
   logic          w_we_nxt;
   logic [3:0]    w_cnt_nxt;
   logic          w_m_en_nxt;
   logic          w_m_we_nxt;
   logic [AW-1:0] w_m_addr_nxt;
   logic [DW-1:0] w_m_wdata_nxt;
   logic          w_i_ack_nxt;
   logic          w_d_ack_nxt;
   logic [DW-1:0] w_i_rdata_nxt;
   logic [DW-1:0] w_d_rdata_nxt;
   logic          w_busy_nxt;
   logic          w_win_d;

   // D wins when alone, or on a tie when I owned the last transaction.
   assign w_win_d = d_req & (~i_req | ~r_grant);

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_grant   <= 1'b1;
         r_we      <= 1'b0;
         r_cnt     <= 4'd0;
         r_m_en    <= 1'b0;
         r_m_we    <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_i_ack   <= 1'b0;
         r_d_ack   <= 1'b0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_we      <= w_we_nxt;
         r_cnt     <= w_cnt_nxt;
         r_m_en    <= w_m_en_nxt;
         r_m_we    <= w_m_we_nxt;
         r_m_addr  <= w_m_addr_nxt;
         r_m_wdata <= w_m_wdata_nxt;
         r_i_ack   <= w_i_ack_nxt;
         r_d_ack   <= w_d_ack_nxt;
         r_i_rdata <= w_i_rdata_nxt;
         r_d_rdata <= w_d_rdata_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_we_nxt      = r_we;
      w_cnt_nxt     = r_cnt;
      w_m_en_nxt    = 1'b0;
      w_m_we_nxt    = 1'b0;
      w_m_addr_nxt  = r_m_addr;
      w_m_wdata_nxt = r_m_wdata;
      w_i_ack_nxt   = 1'b0;
      w_d_ack_nxt   = 1'b0;
      w_i_rdata_nxt = r_i_rdata;
      w_d_rdata_nxt = r_d_rdata;
      case (r_state)
         ST_IDLE: begin
            if (i_req | d_req) begin
               w_state_nxt = ST_ISSUE;
               w_grant_nxt = w_win_d;
               w_m_en_nxt  = 1'b1;
               if (w_win_d) begin
                  w_we_nxt      = d_we;
                  w_m_we_nxt    = d_we;
                  w_m_addr_nxt  = d_addr;
                  w_m_wdata_nxt = d_wdata;
               end else begin
                  w_we_nxt     = 1'b0;
                  w_m_addr_nxt = i_addr;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            w_cnt_nxt   = LAT_LD;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            // Last wait cycle: m_rdata is valid now, ack goes out next cycle.
            if (r_cnt == 4'd1) begin
               w_state_nxt = ST_RESP;
               w_i_ack_nxt = ~r_grant;
               w_d_ack_nxt = r_grant;
               if (r_we) begin
                  w_d_rdata_nxt = r_d_rdata;
               end else if (r_grant) begin
                  w_d_rdata_nxt = m_rdata;
               end else begin
                  w_i_rdata_nxt = m_rdata;
               end
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   assign i_ack   = r_i_ack;
   assign d_ack   = r_d_ack;
   assign i_rdata = r_i_rdata;
   assign d_rdata = r_d_rdata;
   assign m_en    = r_m_en;
   assign m_we    = r_m_we;
   assign m_addr  = r_m_addr;
   assign m_wdata = r_m_wdata;
   assign busy    = r_busy;
   assign grant   = r_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2 and a small fixed-latency memory model.
module tb_mem_port_arbiter;

   localparam int LAT = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;

   logic          clk;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_ack;
   logic [DW-1:0] i_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ack;
   logic [DW-1:0] d_rdata;
   logic          m_en;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          busy;
   logic          grant;

   int n_checks;
   int n_errors;

   mem_port_arbiter #(.MEM_LAT(LAT), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .busy(busy), .grant(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: data valid only in the cycle exactly LAT cycles after the m_en cycle.
   logic [31:0]    mem [0:63];
   logic           mem_clr;
   logic [LAT-1:0] pv;
   logic [31:0]    pd [0:LAT-1];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int k = 0; k < 64; k++) mem[k] <= 32'hC0DE_0000 + 32'(k);
         mem[4] <= 32'hDEAD_BEEF;
      end else if (m_en && m_we) begin
         mem[m_addr[7:2]] <= m_wdata;
      end
      if (rst) pv <= '0;
      else begin
         pv[0] <= m_en && !m_we;
         for (int k = 1; k < LAT; k++) pv[k] <= pv[k-1];
      end
      pd[0] <= mem[m_addr[7:2]];
      for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
   end

   assign m_rdata = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0_BAD0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ack;
      int last_cyc;
      n_checks = 0;
      n_errors = 0;
      mem_clr = 1'b1;
      rst = 1'b1;
      i_req = 1'b1; i_addr = 32'h0000_0010;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040; d_wdata = 32'h0;

      // 1: reset with both requests high
      step(); step();
      mem_clr = 1'b0;
      check_val("rst_i_ack", {31'd0, i_ack}, 32'd0);
      check_val("rst_d_ack", {31'd0, d_ack}, 32'd0);
      check_val("rst_m_en",  {31'd0, m_en},  32'd0);
      check_val("rst_m_we",  {31'd0, m_we},  32'd0);
      check_val("rst_busy",  {31'd0, busy},  32'd0);
      check_val("rst_grant", {31'd0, grant}, 32'd1);
      check_val("rst_i_rdata", i_rdata, 32'd0);
      check_val("rst_d_rdata", d_rdata, 32'd0);
      i_req = 1'b0; d_req = 1'b0; rst = 1'b0;
      step();

      // 2: single fetch
      i_req = 1'b1; i_addr = 32'h0000_0010;
      step();
      check_val("f_m_en",   {31'd0, m_en}, 32'd1);
      check_val("f_m_we",   {31'd0, m_we}, 32'd0);
      check_val("f_m_addr", m_addr, 32'h0000_0010);
      step(); step();
      check_val("f_ack_early", {31'd0, i_ack}, 32'd0);
      step();
      check_val("f_i_ack",   {31'd0, i_ack}, 32'd1);
      check_val("f_i_rdata", i_rdata, 32'hDEAD_BEEF);
      i_req = 1'b0;
      step();
      check_val("f_busy_after", {31'd0, busy}, 32'd0);
      check_val("f_ack_pulse",  {31'd0, i_ack}, 32'd0);

      // 3: data write
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0040; d_wdata = 32'h0000_1234;
      step();
      check_val("w_m_en",    {31'd0, m_en}, 32'd1);
      check_val("w_m_we",    {31'd0, m_we}, 32'd1);
      check_val("w_m_wdata", m_wdata, 32'h0000_1234);
      step();
      check_val("w_m_we_off", {31'd0, m_we}, 32'd0);
      step(); step();
      check_val("w_d_ack",   {31'd0, d_ack}, 32'd1);
      check_val("w_d_rdata", d_rdata, 32'd0);
      check_val("w_grant",   {31'd0, grant}, 32'd1);
      d_req = 1'b0; d_we = 1'b0;
      step();

      // 4: simultaneous requests straight after reset
      rst = 1'b1; step(); rst = 1'b0; step();
      i_req = 1'b1; i_addr = 32'h0000_0010;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
      step();
      check_val("s_m_addr_i", m_addr, 32'h0000_0010);
      check_val("s_grant_i",  {31'd0, grant}, 32'd0);
      step(); step(); step();
      check_val("s_i_ack",   {31'd0, i_ack}, 32'd1);
      check_val("s_d_ack0",  {31'd0, d_ack}, 32'd0);
      check_val("s_i_rdata", i_rdata, 32'hDEAD_BEEF);
      i_req = 1'b0;
      step();
      check_val("s_idle5", {31'd0, busy}, 32'd0);
      step();
      check_val("s_m_en6",    {31'd0, m_en}, 32'd1);
      check_val("s_m_addr_d", m_addr, 32'h0000_0040);
      check_val("s_grant_d",  {31'd0, grant}, 32'd1);
      step(); step(); step();
      check_val("s_d_ack9",  {31'd0, d_ack}, 32'd1);
      check_val("s_d_rdata", d_rdata, 32'h0000_1234);
      d_req = 1'b0;
      step();

      // 5: continuous contention, 8 transactions
      rst = 1'b1; step(); rst = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      n_ack = 0; last_cyc = 0;
      for (int cyc = 1; cyc <= 60 && n_ack < 8; cyc++) begin
         step();
         if (i_ack || d_ack) begin
            check_val("rr_both", {31'd0, i_ack & d_ack}, 32'd0);
            check_val("rr_port", {31'd0, d_ack}, 32'(n_ack % 2));
            if (n_ack > 0) check_val("rr_gap", 32'(cyc - last_cyc), 32'd5);
            if (i_ack) check_val("rr_i_rdata", i_rdata, 32'hDEAD_BEEF);
            else       check_val("rr_d_rdata", d_rdata, 32'h0000_1234);
            last_cyc = cyc;
            n_ack++;
         end
      end
      check_val("rr_count", 32'(n_ack), 32'd8);
      i_req = 1'b0; d_req = 1'b0;

      // 6: reset during WAIT of a fetch, then reissue
      rst = 1'b1; step(); rst = 1'b0; step();
      i_req = 1'b1; i_addr = 32'h0000_0010;
      step();
      check_val("r_m_en1", {31'd0, m_en}, 32'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("r_m_en_off", {31'd0, m_en}, 32'd0);
      check_val("r_busy_off", {31'd0, busy}, 32'd0);
      check_val("r_i_rdata0", i_rdata, 32'd0);
      for (int k = 0; k < LAT + 1; k++) begin
         step();
         check_val("r_no_ack", {31'd0, i_ack}, 32'd0);
      end
      step();
      check_val("r_reissue_ack", {31'd0, i_ack}, 32'd1);
      check_val("r_reissue_data", i_rdata, 32'hDEAD_BEEF);
      i_req = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
